// File: rtl/adc_capture_mux.sv
// ADC capture front end: drives ad_clk, captures NCH parallel channels, optionally averages
// 2^AVG_LOG2 samples per channel and serialises the results onto a valid/ready port.
module adc_capture_mux #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned DW         = 12,
    parameter int unsigned DIV        = 4,
    parameter int unsigned AVG_LOG2   = 0,
    parameter int unsigned SIGNED_OUT = 1,
    localparam int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              ad_clk,
    input  logic [NCH*DW-1:0] ad_in,
    output logic [DW-1:0]     m_data,
    output logic [CW-1:0]     m_chan,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int unsigned AW  = DW + AVG_LOG2;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned SCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PW-1:0]  CntLast   = PW'(DIV - 1);
    localparam logic [PW-1:0]  CntStrobe = PW'(DIV / 2 - 1);
    localparam logic [PW-1:0]  CntHigh   = PW'(DIV / 2);
    localparam logic [SCW-1:0] SampLast  = SCW'((1 << AVG_LOG2) - 1);

    logic [PW-1:0]  cnt_q, cnt_d;
    logic           ad_clk_q, ad_clk_d;
    logic           strobe;
    logic [DW-1:0]  cap_q [NCH];
    logic [DW-1:0]  cap_d [NCH];
    logic           cap_vld_q, cap_vld_d;

    logic [AW-1:0]  acc_q [NCH];
    logic [AW-1:0]  acc_d [NCH];
    logic [SCW-1:0] samp_cnt_q, samp_cnt_d;
    logic [DW-1:0]  res [NCH];
    logic           frame_done;
    logic [DW-1:0]  conv;
    logic signed [DW-1:0] conv_s;
    logic [AW-1:0]  ext;
    logic [AW-1:0]  sum;
    logic signed [AW-1:0] sum_s;

    logic [DW-1:0]  hold_q [NCH];
    logic [DW-1:0]  hold_d [NCH];
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] take;
    logic           load;
    logic           any_pend;
    logic [CW-1:0]  sel_chan;
    logic [DW-1:0]  sel_data;
    logic           overrun_set;

    logic           m_valid_q, m_valid_d;
    logic [DW-1:0]  m_data_q, m_data_d;
    logic [CW-1:0]  m_chan_q, m_chan_d;
    logic           overrun_q, overrun_d;

    // Phase counter, ad_clk and capture strobe on the last low-phase cycle.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + PW'(1);
        end
        ad_clk_d  = en && (cnt_d >= CntHigh);
        strobe    = en && (cnt_q == CntStrobe);
        cap_vld_d = strobe;
        for (int k = 0; k < int'(NCH); k++) begin
            cap_d[k] = strobe ? ad_in[k*DW +: DW] : cap_q[k];
        end
    end

    // Conversion and accumulation, one cycle after capture.
    always_comb begin
        samp_cnt_d = samp_cnt_q;
        frame_done = 1'b0;
        conv       = '0;
        conv_s     = '0;
        ext        = '0;
        sum        = '0;
        sum_s      = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            acc_d[k] = acc_q[k];
            res[k]   = '0;
        end
        if (!en) begin
            samp_cnt_d = '0;
            for (int k = 0; k < int'(NCH); k++) begin
                acc_d[k] = '0;
            end
        end else if (cap_vld_q) begin
            frame_done = (samp_cnt_q == SampLast);
            samp_cnt_d = frame_done ? '0 : samp_cnt_q + SCW'(1);
            for (int k = 0; k < int'(NCH); k++) begin
                conv = cap_q[k];
                if (SIGNED_OUT != 0) begin
                    conv[DW-1] = ~conv[DW-1];
                end
                conv_s = conv;
                ext    = (SIGNED_OUT != 0) ? AW'(conv_s) : AW'(conv);
                sum    = acc_q[k] + ext;
                sum_s  = sum;
                if (frame_done) begin
                    res[k]   = (SIGNED_OUT != 0) ? DW'(sum_s >>> AVG_LOG2) : DW'(sum >> AVG_LOG2);
                    acc_d[k] = '0;
                end else begin
                    acc_d[k] = sum;
                end
            end
        end
    end

    // Hold registers and output serialiser; lowest pending channel wins.
    always_comb begin
        load      = !m_valid_q || m_ready;
        take      = pend_q & (~pend_q + NCH'(1));
        any_pend  = |pend_q;
        sel_chan  = '0;
        sel_data  = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            hold_d[k] = hold_q[k];
            if (take[k]) begin
                sel_chan = CW'(k);
                sel_data = hold_q[k];
            end
        end
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_chan_d    = m_chan_q;
        pend_d      = pend_q;
        overrun_set = 1'b0;
        if (load) begin
            m_valid_d = any_pend;
            if (any_pend) begin
                m_data_d = sel_data;
                m_chan_d = sel_chan;
                pend_d   = pend_q & ~take;
            end
        end
        if (frame_done) begin
            for (int k = 0; k < int'(NCH); k++) begin
                // A channel handed to the output on this edge is not an overwrite.
                if (pend_q[k] && !(load && take[k])) begin
                    overrun_set = 1'b1;
                end
                hold_d[k] = res[k];
                pend_d[k] = 1'b1;
            end
        end
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            ad_clk_q   <= 1'b0;
            cap_vld_q  <= 1'b0;
            samp_cnt_q <= '0;
            pend_q     <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_chan_q   <= '0;
            overrun_q  <= 1'b0;
            for (int k = 0; k < int'(NCH); k++) begin
                cap_q[k]  <= '0;
                acc_q[k]  <= '0;
                hold_q[k] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            ad_clk_q   <= ad_clk_d;
            cap_vld_q  <= cap_vld_d;
            samp_cnt_q <= samp_cnt_d;
            pend_q     <= pend_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_chan_q   <= m_chan_d;
            overrun_q  <= overrun_d;
            for (int k = 0; k < int'(NCH); k++) begin
                cap_q[k]  <= cap_d[k];
                acc_q[k]  <= acc_d[k];
                hold_q[k] <= hold_d[k];
            end
        end
    end

    assign ad_clk  = ad_clk_q;
    assign m_data  = m_data_q;
    assign m_chan  = m_chan_q;
    assign m_valid = m_valid_q;
    assign overrun = overrun_q;

endmodule
